// File: rtl/gpio_button_in.sv
// gpio_button_in: synchronized, debounced 4-button input with prioritized press-event handshake
module gpio_button_in #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  output logic [3:0] btn_level,
  output logic       press_valid,
  output logic [1:0] press_code,
  input  logic       press_ready,
  output logic       overflow,
  input  logic       ovf_clr
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [3:0] sync1, sync2, pending, acc, press, clr;
  logic [CNT_W-1:0] cnt [4];
  always_comb begin
    for (int i = 0; i < 4; i++) acc[i] = (sync2[i] != btn_level[i]) && (cnt[i] == LAST);
    press = acc & sync2 & ~btn_level;
    press_valid = |pending;
    press_code = pending[0] ? 2'd0 : pending[1] ? 2'd1 : pending[2] ? 2'd2 : pending[3] ? 2'd3 : 2'd0;
    clr = (press_valid && press_ready) ? 4'b0001 << press_code : 4'b0000;
  end
  // a press landing on its own handshake edge survives because press is OR-ed after the clear
  always_ff @(posedge clk)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      btn_level <= '0;
      pending <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      btn_level <= btn_level ^ acc;
      for (int i = 0; i < 4; i++) cnt[i] <= (sync2[i] == btn_level[i] || acc[i]) ? '0 : cnt[i] + CNT_W'(1);
      pending <= (pending & ~clr) | press;
      overflow <= (|(press & pending & ~clr)) | (overflow & ~ovf_clr);
    end
endmodule
